filter_sp_read_ctrl: RTL and testbench

- Owns the write and read pointers of the filter scratchpad in the convolution PE.
- Packs as many whole filters as fit into an SP_DEPTH scratchpad.
- Streams each filter out reuse_count times (one replay per input window), then advances to the next filter.
- Generalises the earlier combinational filter read control with internal pointers, ready/valid handshakes, runtime filter size, filter reuse and completion signalling.

---
 rtl/filter_sp_read_ctrl.sv | 176 +++++++++++++++++
 tb/tb_filter_sp_read_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/filter_sp_read_ctrl.sv
// Filter scratchpad pointer controller: packs whole filters into the scratchpad and replays each one reuse_count times.
// Optional stall counter output is enabled by defining FILTER_SP_STALL_CNT_EN.
module filter_sp_read_ctrl #(
    parameter int SP_DEPTH = 16,
    parameter int PTR_W    = 8,
    parameter int SIZE_W   = 8,
    parameter int REUSE_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SIZE_W-1:0]  filter_size,
    input  logic [REUSE_W-1:0] reuse_count,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               wr_en,
    output logic [PTR_W-1:0]   wr_addr,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [PTR_W-1:0]   rd_addr,
    output logic               end_of_filter,
    output logic               last_filter,
    output logic               done,
    output logic               cfg_err,
`ifdef FILTER_SP_STALL_CNT_EN
    output logic [15:0]        stall_cnt,
`endif
    output logic               busy
);
    // One extra bit so base+filter_size and limit never wrap.
    localparam int EW = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [EW-1:0]      fs_q, fs_d;
    logic [EW-1:0]      limit_q, limit_d;
    logic [EW-1:0]      base_q, base_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   offset_q, offset_d;
    logic [REUSE_W-1:0] reuse_q, reuse_d;
    logic [REUSE_W-1:0] pass_q, pass_d;
    logic               cfg_err_q, cfg_err_d;

    logic [EW-1:0]      rd_ext;
    logic [EW-1:0]      base_next;
    logic               run, fire, last_pass, cfg_bad, start_ok;

    assign run       = (state_q == S_RUN);
    assign cfg_bad   = (filter_size == '0) || (32'(filter_size) > 32'(SP_DEPTH));
    assign start_ok  = (state_q == S_IDLE) && start && !cfg_bad;

    assign in_ready  = run && ({1'b0, wr_ptr_q} < limit_q);
    assign wr_en     = in_valid && in_ready;
    assign wr_addr   = wr_ptr_q;

    assign rd_ext    = base_q + {1'b0, offset_q};
    assign rd_addr   = rd_ext[PTR_W-1:0];
    // Registered write pointer: a word becomes readable the cycle after its write.
    assign out_valid = run && (rd_ext < {1'b0, wr_ptr_q});
    assign end_of_filter = out_valid && ({1'b0, offset_q} == fs_q - EW'(1));
    assign base_next = base_q + fs_q;
    assign last_filter = run && (base_next == limit_q);
    assign last_pass = (pass_q == reuse_q - REUSE_W'(1));
    assign fire      = out_valid && out_ready;

    assign done      = (state_q == S_DONE);
    assign cfg_err   = cfg_err_q;
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        state_d   = state_q;
        fs_d      = fs_q;
        limit_d   = limit_q;
        base_d    = base_q;
        wr_ptr_d  = wr_ptr_q;
        offset_d  = offset_q;
        reuse_d   = reuse_q;
        pass_d    = pass_q;
        cfg_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && cfg_bad) begin
                    cfg_err_d = 1'b1;
                end else if (start_ok) begin
                    fs_d     = EW'(filter_size);
                    reuse_d  = (reuse_count == '0) ? REUSE_W'(1) : reuse_count;
                    limit_d  = '0;
                    base_d   = '0;
                    wr_ptr_d = '0;
                    offset_d = '0;
                    pass_d   = '0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                if (limit_q + fs_q <= EW'(SP_DEPTH)) begin
                    limit_d = limit_q + fs_q;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (wr_en) begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                end
                if (fire) begin
                    if (!end_of_filter) begin
                        offset_d = offset_q + PTR_W'(1);
                    end else if (!last_pass) begin
                        pass_d   = pass_q + REUSE_W'(1);
                        offset_d = '0;
                    end else begin
                        pass_d   = '0;
                        offset_d = '0;
                        base_d   = base_next;
                        if (last_filter) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            fs_q      <= '0;
            limit_q   <= '0;
            base_q    <= '0;
            wr_ptr_q  <= '0;
            offset_q  <= '0;
            reuse_q   <= '0;
            pass_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fs_q      <= fs_d;
            limit_q   <= limit_d;
            base_q    <= base_d;
            wr_ptr_q  <= wr_ptr_d;
            offset_q  <= offset_d;
            reuse_q   <= reuse_d;
            pass_q    <= pass_d;
            cfg_err_q <= cfg_err_d;
        end
    end

`ifdef FILTER_SP_STALL_CNT_EN
    // Counts RUN cycles where the MAC was ready but no written word was available.
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_ok) begin
            stall_d = '0;
        end else if (run && out_ready && !out_valid && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_filter_sp_read_ctrl.sv
// Randomized self-checking bench for filter_sp_read_ctrl against a queue-based model of the expected read stream.
// Also checks stall_cnt when FILTER_SP_STALL_CNT_EN is defined.
module tb_filter_sp_read_ctrl;
    localparam int SP = 16;

    logic       clk = 1'b0;
    logic       rst, start, in_valid, out_ready;
    logic [7:0] filter_size, reuse_count;
    logic       in_ready, wr_en, out_valid, end_of_filter, last_filter, done, cfg_err, busy;
    logic [7:0] wr_addr, rd_addr;
`ifdef FILTER_SP_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    typedef struct {
        int addr;
        bit eof;
        bit last;
    } rd_t;

    always #5 clk = ~clk;

    filter_sp_read_ctrl #(
        .SP_DEPTH(SP), .PTR_W(8), .SIZE_W(8), .REUSE_W(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .filter_size(filter_size), .reuse_count(reuse_count),
        .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .out_ready(out_ready), .out_valid(out_valid), .rd_addr(rd_addr),
        .end_of_filter(end_of_filter), .last_filter(last_filter),
        .done(done), .cfg_err(cfg_err),
`ifdef FILTER_SP_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_eof"}, end_of_filter, 0);
        chk({tag, "_last"}, last_filter, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cfg_err"}, cfg_err, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Starts at a falling edge and returns on a falling edge with the DUT idle.
    task automatic run_job(input int fs, input int reuse, input int pin, input int pout,
                           input int hold, input int abort_at);
        rd_t exp_q[$];
        rd_t e;
        int  nf, lim, r, wr_cnt, rd_idx, cyc, stall_exp;
        bit  exp_valid, exp_wr;
        nf  = SP / fs;
        lim = nf * fs;
        r   = (reuse == 0) ? 1 : reuse;
        for (int f = 0; f < nf; f++)
            for (int p = 0; p < r; p++)
                for (int o = 0; o < fs; o++) begin
                    e.addr = f * fs + o;
                    e.eof  = (o == fs - 1);
                    e.last = (f == nf - 1);
                    exp_q.push_back(e);
                end

        filter_size = 8'(fs);
        reuse_count = 8'(reuse);
        start       = 1'b1;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= nf; i++) begin
            #1;
            chk("calc_busy", busy, 1);
            chk("calc_in_ready", in_ready, 0);
            chk("calc_wr_en", wr_en, 0);
            chk("calc_out_valid", out_valid, 0);
            chk("calc_cfg_err", cfg_err, 0);
`ifdef FILTER_SP_STALL_CNT_EN
            chk("calc_stall_cnt", stall_cnt, 0);
`endif
            @(negedge clk);
        end

        wr_cnt = 0; rd_idx = 0; cyc = 0; stall_exp = 0;
        while (rd_idx < exp_q.size() && cyc < 3000) begin
            if (abort_at > 0 && cyc == abort_at) break;
            in_valid    = (cyc >= hold) && ($urandom_range(99) < pin);
            out_ready   = ($urandom_range(99) < pout);
            start       = ($urandom_range(7) == 0);
            filter_size = 8'($urandom_range(0, 40));
            reuse_count = 8'($urandom_range(0, 5));
            #1;
            exp_valid = (exp_q[rd_idx].addr < wr_cnt);
            exp_wr    = in_valid && (wr_cnt < lim);
            chk("run_busy", busy, 1);
            chk("in_ready", in_ready, wr_cnt < lim);
            chk("wr_en", wr_en, exp_wr);
            if (exp_wr) chk("wr_addr", wr_addr, wr_cnt);
            chk("out_valid", out_valid, exp_valid);
            if (exp_valid) begin
                chk("rd_addr", rd_addr, exp_q[rd_idx].addr);
                chk("end_of_filter", end_of_filter, exp_q[rd_idx].eof);
                chk("last_filter", last_filter, exp_q[rd_idx].last);
            end
            chk("done_early", done, 0);
            chk("cfg_err_run", cfg_err, 0);
            if (out_ready && !exp_valid) stall_exp++;
            if (exp_wr) wr_cnt++;
            if (exp_valid && out_ready) rd_idx++;
            cyc++;
            @(negedge clk);
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        if (abort_at > 0) begin
            rst = 1'b1;
            @(negedge clk);
            #1;
            chk_idle_zero("abort");
            rst = 1'b0;
            @(negedge clk);
            #1;
            chk("abort_no_done", done, 0);
            chk("abort_idle", busy, 0);
            @(negedge clk);
        end else begin
            chk("reads_complete", rd_idx, exp_q.size());
            chk("writes_total", wr_cnt, lim);
            #1;
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 1);
`ifdef FILTER_SP_STALL_CNT_EN
            chk("stall_cnt", stall_cnt, stall_exp);
`endif
            @(negedge clk);
            #1;
            chk("done_clear", done, 0);
            chk("idle_busy", busy, 0);
            chk("idle_in_ready", in_ready, 0);
            @(negedge clk);
        end
        $display("job fs=%0d reuse=%0d reads=%0d writes=%0d cycles=%0d", fs, reuse, rd_idx, wr_cnt, cyc);
    endtask

    task automatic bad_cfg(input int fs);
        filter_size = 8'(fs);
        reuse_count = 8'd1;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("cfg_err_pulse", cfg_err, 1);
        chk("cfg_err_busy", busy, 0);
        @(negedge clk);
        #1;
        chk("cfg_err_clear", cfg_err, 0);
        chk("cfg_err_idle", busy, 0);
        @(negedge clk);
        $display("bad config fs=%0d", fs);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; filter_size = '0; reuse_count = '0;
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_idle_zero("reset");
`ifdef FILTER_SP_STALL_CNT_EN
        chk("reset_stall_cnt", stall_cnt, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        run_job(5, 1, 100, 100, 0, 0);
        run_job(5, 2, 100, 100, 0, 0);
        run_job(5, 2, 33, 100, 0, 0);
        run_job(5, 2, 100, 50, 0, 0);
        run_job(3, 0, 70, 70, 0, 0);
        run_job(16, 3, 80, 60, 0, 0);
        run_job(1, 2, 50, 50, 0, 0);
        run_job(4, 1, 100, 100, 6, 0);
        run_job(16, 1, 100, 100, 0, 0);
        bad_cfg(0);
        bad_cfg(17);
        bad_cfg(255);
        run_job(4, 2, 100, 100, 0, 5);
        run_job(6, 2, 60, 60, 0, 0);
        for (int k = 0; k < 6; k++) begin
            run_job(int'($urandom_range(1, 16)), int'($urandom_range(0, 3)),
                    int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
